router_out_arb: RTL

ROUTER_OUT_ARB -- requirements
Module: router_out_arb

---
 rtl/router_pkg.sv | 50 +++++
 rtl/router_rr_pick.sv | 34 +++
 rtl/router_out_arb.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and helpers for the router output arbiter: FSM encoding,
// port-count constants and small port-index helper functions.
package router_pkg;

   localparam int         NUM_PORTS   = 3;
   localparam logic [4:0] TIMEOUT_CYC = 5'd30;
   localparam logic [1:0] GRANT_NONE  = 2'd3;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_HDR  = 2'd1;
   localparam state_t ST_HLEN = 2'd2;
   localparam state_t ST_BODY = 2'd3;

   // Next port in round-robin order; an out-of-range index restarts at port 0.
   function automatic logic [1:0] rr_next(input logic [1:0] p);
      logic [1:0] n;
      case (p)
         2'd0:    n = 2'd1;
         2'd1:    n = 2'd2;
         default: n = 2'd0;
      endcase
      return n;
   endfunction

   function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [1:0] p);
      logic [NUM_PORTS-1:0] oh;
      case (p)
         2'd0:    oh = 3'b001;
         2'd1:    oh = 3'b010;
         2'd2:    oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

   function automatic logic [7:0] mux3(input logic [1:0] sel, input logic [7:0] a,
                                       input logic [7:0] b, input logic [7:0] c);
      logic [7:0] r;
      case (sel)
         2'd0:    r = a;
         2'd1:    r = b;
         2'd2:    r = c;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/router_rr_pick.sv
// Combinational 3-way round-robin picker: searches last+1, last+2, last+3 (mod 3).
module router_rr_pick
   import router_pkg::*;
(
   input  logic [NUM_PORTS-1:0] req_i,
   input  logic [1:0]           last_i,
   output logic [1:0]           gnt_o,
   output logic                 any_o
);

   logic [1:0] cand0_s;
   logic [1:0] cand1_s;
   logic [1:0] cand2_s;

   assign cand0_s = rr_next(last_i);
   assign cand1_s = rr_next(cand0_s);
   assign cand2_s = rr_next(cand1_s);
   assign any_o   = |req_i;

   // First requesting candidate in search order wins.
   always_comb begin
      gnt_o = GRANT_NONE;
      if (|(req_i & port_onehot(cand0_s))) begin
         gnt_o = cand0_s;
      end else if (|(req_i & port_onehot(cand1_s))) begin
         gnt_o = cand1_s;
      end else if (|(req_i & port_onehot(cand2_s))) begin
         gnt_o = cand2_s;
      end else begin
         gnt_o = GRANT_NONE;
      end
   end

endmodule

// File: rtl/router_out_arb.sv
// Router output arbiter: round-robin drains one packet at a time from three
// output FIFOs onto a shared byte channel, flushing a port that stalls too long.
module router_out_arb
   import router_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic       fifo_empty_0,
   input  logic       fifo_empty_1,
   input  logic       fifo_empty_2,
   input  logic [7:0] fifo_dout_0,
   input  logic [7:0] fifo_dout_1,
   input  logic [7:0] fifo_dout_2,
   input  logic       ready_out,
   output logic       read_enb_0,
   output logic       read_enb_1,
   output logic       read_enb_2,
   output logic [7:0] data_out,
   output logic       vld_out,
   output logic [1:0] grant,
   output logic       soft_reset_0,
   output logic       soft_reset_1,
   output logic       soft_reset_2,
   output logic       busy
);

   state_t               state_q, state_d;
   logic [1:0]           grant_q, grant_d;
   logic [1:0]           last_grant_q, last_grant_d;
   logic [6:0]           remaining_q, remaining_d;
   logic [4:0]           idle_cnt_q, idle_cnt_d;
   logic [NUM_PORTS-1:0] soft_reset_q, soft_reset_d;
   logic                 vld_q;
   logic [1:0]           sel_q, sel_d;

   logic [NUM_PORTS-1:0] req_s;
   logic [NUM_PORTS-1:0] rd_vec_s;
   logic [1:0]           pick_s;
   logic                 pick_any_s;
   logic                 rd_s;
   logic [4:0]           cnt_inc_s;
   logic                 timeout_s;
   logic [7:0]           rd_byte_s;

   assign req_s = ~{fifo_empty_2, fifo_empty_1, fifo_empty_0};

   router_rr_pick u_pick (
      .req_i  (req_s),
      .last_i (last_grant_q),
      .gnt_o  (pick_s),
      .any_o  (pick_any_s)
   );

   // Read strobe: only the granted port, only in HDR/BODY, only when it can move.
   always_comb begin
      rd_s = 1'b0;
      if ((state_q == ST_HDR) || (state_q == ST_BODY)) begin
         rd_s = ready_out & (|(req_s & port_onehot(grant_q)));
      end else begin
         rd_s = 1'b0;
      end
   end

   assign rd_vec_s   = rd_s ? port_onehot(grant_q) : 3'b000;
   assign read_enb_0 = rd_vec_s[0];
   assign read_enb_1 = rd_vec_s[1];
   assign read_enb_2 = rd_vec_s[2];

   assign cnt_inc_s = idle_cnt_q + 5'd1;
   assign timeout_s = (cnt_inc_s == TIMEOUT_CYC);

   // In HLEN the header was read last cycle, so sel_q already equals grant_q.
   assign rd_byte_s = mux3(sel_q, fifo_dout_0, fifo_dout_1, fifo_dout_2);
   assign data_out  = vld_q ? rd_byte_s : 8'h00;
   assign vld_out   = vld_q;
   assign grant     = grant_q;
   assign busy      = (state_q != ST_IDLE);

   assign soft_reset_0 = soft_reset_q[0];
   assign soft_reset_1 = soft_reset_q[1];
   assign soft_reset_2 = soft_reset_q[2];

   assign sel_d = rd_s ? grant_q : sel_q;

   // Packet FSM: arbitration, length capture, body countdown and stall timeout.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      remaining_d  = remaining_q;
      idle_cnt_d   = idle_cnt_q;
      soft_reset_d = 3'b000;
      case (state_q)
         ST_IDLE: begin
            idle_cnt_d = 5'd0;
            if (pick_any_s) begin
               grant_d = pick_s;
               state_d = ST_HDR;
            end else begin
               grant_d = GRANT_NONE;
               state_d = ST_IDLE;
            end
         end
         ST_HLEN: begin
            remaining_d = {1'b0, rd_byte_s[7:2]} + 7'd1;
            idle_cnt_d  = 5'd0;
            state_d     = ST_BODY;
         end
         ST_HDR, ST_BODY: begin
            if (rd_s) begin
               idle_cnt_d = 5'd0;
               if (state_q == ST_HDR) begin
                  state_d = ST_HLEN;
               end else if (remaining_q == 7'd1) begin
                  remaining_d  = 7'd0;
                  last_grant_d = grant_q;
                  grant_d      = GRANT_NONE;
                  state_d      = ST_IDLE;
               end else begin
                  remaining_d = remaining_q - 7'd1;
               end
            end else if (timeout_s) begin
               soft_reset_d = port_onehot(grant_q);
               last_grant_d = grant_q;
               grant_d      = GRANT_NONE;
               remaining_d  = 7'd0;
               idle_cnt_d   = 5'd0;
               state_d      = ST_IDLE;
            end else begin
               idle_cnt_d = cnt_inc_s;
            end
         end
         default: begin
            grant_d = GRANT_NONE;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any packet without a flush.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         grant_q      <= GRANT_NONE;
         last_grant_q <= 2'd2;
         remaining_q  <= 7'd0;
         idle_cnt_q   <= 5'd0;
         soft_reset_q <= 3'b000;
         vld_q        <= 1'b0;
         sel_q        <= 2'd0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         remaining_q  <= remaining_d;
         idle_cnt_q   <= idle_cnt_d;
         soft_reset_q <= soft_reset_d;
         vld_q        <= rd_s;
         sel_q        <= sel_d;
      end
   end

endmodule
